sd_clk_gen: RTL and testbench

//  SD-bus clock generator, directly downstream of the system PLL. Clocked by the PLL's 75 MHz CLKOUT.

---
 rtl/sd_clk_gen.sv | 145 ++++++++++++++
 tb/tb_sd_clk_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_clk_gen.sv
// SD card clock divider with power-up init burst and glitch-free gating.
// Define SD_CLK_HOLD_EN to let hold_i park the clock low while running.
module sd_clk_gen #(
    parameter int DIV_W       = 8,
    parameter int INIT_DIV    = 93,
    parameter int INIT_CYCLES = 80
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_load_i,
    output logic             div_ack_o,
    input  logic             en_i,
    input  logic             hold_i,
    input  logic             init_start_i,
    output logic             busy_o,
    output logic             init_done_o,
    output logic             sd_clk_o,
    output logic             rise_o,
    output logic             fall_o
);

    localparam int EW = $clog2(INIT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN
    } state_t;

    state_t state, state_nxt;

    logic [DIV_W-1:0] div_cur;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] pend_div;
    logic             pend_vld;
    logic [EW-1:0]    edge_cnt;

    logic             hold_eff;
    logic             running;
    logic             cnt_zero;
    logic             init_fin;
    logic             gate;
    logic             do_rise;
    logic             do_fall;
    logic             parked;
    logic             load_vld;
    logic [DIV_W-1:0] load_div;
    logic             apply;
    logic             start_ok;

`ifdef SD_CLK_HOLD_EN
    assign hold_eff = hold_i;
`else
    logic unused_hold;
    assign unused_hold = hold_i;
    assign hold_eff    = 1'b0;
`endif

    assign running  = (state != S_IDLE);
    assign cnt_zero = (cnt == '0);
    // burst finished: last fall done, suppress any further rise in INIT
    assign init_fin = (state == S_INIT) && !sd_clk_o &&
                      (edge_cnt == EW'(INIT_CYCLES));
    assign gate     = ((state == S_RUN) && (!en_i || hold_eff)) || init_fin;
    assign do_fall  = running && cnt_zero && sd_clk_o;
    assign do_rise  = running && cnt_zero && !sd_clk_o && !gate;
    assign parked   = !sd_clk_o && ((state == S_IDLE) || (cnt_zero && gate));
    // a load in the same cycle bypasses the pending register
    assign load_vld = div_load_i || pend_vld;
    assign load_div = div_load_i ? div_i : pend_div;
    assign apply    = load_vld && (do_fall || parked);
    assign start_ok = init_start_i && !sd_clk_o &&
                      ((state == S_IDLE) || (state == S_RUN));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start_ok) state_nxt = S_INIT;
            S_INIT:  if (init_fin) state_nxt = S_RUN;
            S_RUN:   if (start_ok) state_nxt = S_INIT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state == S_INIT);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sd_clk_o    <= 1'b0;
            rise_o      <= 1'b0;
            fall_o      <= 1'b0;
            cnt         <= '0;
            div_cur     <= DIV_W'(INIT_DIV);
            div_ack_o   <= 1'b0;
            pend_vld    <= 1'b0;
            pend_div    <= '0;
            edge_cnt    <= '0;
            init_done_o <= 1'b0;
        end else begin
            if (do_fall) begin
                sd_clk_o <= 1'b0;
                cnt      <= apply ? load_div : div_cur;
            end else if (do_rise) begin
                sd_clk_o <= 1'b1;
                cnt      <= div_cur;
            end else if (running && !cnt_zero) begin
                cnt <= cnt - DIV_W'(1);
            end
            rise_o <= do_rise;
            fall_o <= do_fall;

            if (apply) begin
                div_cur <= load_div;
            end
            div_ack_o <= apply;

            if (apply) begin
                pend_vld <= 1'b0;
            end else if (div_load_i) begin
                pend_vld <= 1'b1;
                pend_div <= div_i;
            end

            if (start_ok) begin
                edge_cnt <= '0;
            end else if ((state == S_INIT) && do_rise) begin
                edge_cnt <= edge_cnt + EW'(1);
            end

            init_done_o <= init_fin;
        end
    end

endmodule

// File: tb/tb_sd_clk_gen.sv
// Bench for sd_clk_gen: event-level reference model plus directed scenarios.
// Build with SD_CLK_HOLD_EN to cover the hold gating variant.
module tb_sd_clk_gen;

`ifdef SD_CLK_HOLD_EN
    localparam bit HOLD_ON = 1'b1;
`else
    localparam bit HOLD_ON = 1'b0;
`endif
    localparam int LIMIT = 20000;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] div_i;
    logic       div_load_i;
    logic       div_ack_o;
    logic       en_i;
    logic       hold_i;
    logic       init_start_i;
    logic       busy_o;
    logic       init_done_o;
    logic       sd_clk_o;
    logic       rise_o;
    logic       fall_o;

    int n_chk  = 0;
    int n_pass = 0;

    // model state: 0 idle, 1 init, 2 run
    int mode, cur_div, m_pend, hw, lw, init_rises;
    bit m_pend_vld, start_due, done_due;
    bit low_valid, low_gated, prev_gate, prev_sd;

    sd_clk_gen dut (
        .clk          (clk),
        .rstn         (rstn),
        .div_i        (div_i),
        .div_load_i   (div_load_i),
        .div_ack_o    (div_ack_o),
        .en_i         (en_i),
        .hold_i       (hold_i),
        .init_start_i (init_start_i),
        .busy_o       (busy_o),
        .init_done_o  (init_done_o),
        .sd_clk_o     (sd_clk_o),
        .rise_o       (rise_o),
        .fall_o       (fall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp);
    endtask

    function automatic logic ev(input int sel);
        case (sel)
            0:       return rise_o;
            1:       return fall_o;
            2:       return div_ack_o;
            default: return init_done_o;
        endcase
    endfunction

    task automatic wait_ev(input int sel, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ev(sel) && n < LIMIT);
        chk("wait_event", ev(sel), 1'b1);
    endtask

    task automatic monitor();
        bit exp_done, exp_ack, gate_now;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                mode       = 0;
                cur_div    = 93;
                m_pend_vld = 0;
                start_due  = 0;
                done_due   = 0;
                low_valid  = 0;
                low_gated  = 0;
                prev_gate  = 1;
                prev_sd    = 0;
                hw         = 0;
                lw         = 0;
                init_rises = 0;
            end else begin
                if (start_due) begin
                    mode       = 1;
                    init_rises = 0;
                    start_due  = 0;
                end
                exp_done = done_due;
                done_due = 0;
                if (exp_done) mode = 2;
                chk("init_done", init_done_o, exp_done);
                chk("busy", busy_o, mode == 1);
                chk("rise_strobe", rise_o, sd_clk_o && !prev_sd);
                chk("fall_strobe", fall_o, !sd_clk_o && prev_sd);
                if (prev_gate) chk("gated_rise", rise_o, 1'b0);
                exp_ack = 0;
                if (rise_o) begin
                    if (low_valid && !low_gated)
                        chk("low_width", lw, cur_div + 1);
                    low_valid = 0;
                    hw = 1;
                    if (mode == 1) init_rises++;
                end else if (fall_o) begin
                    chk("high_width", hw, cur_div + 1);
                    if (m_pend_vld) begin
                        exp_ack    = 1;
                        cur_div    = m_pend;
                        m_pend_vld = 0;
                    end
                    lw        = 1;
                    low_valid = 1;
                    low_gated = 0;
                    if (mode == 1 && init_rises == 80) done_due = 1;
                end else if (sd_clk_o) begin
                    hw++;
                end else begin
                    lw++;
                end
                chk("div_ack", div_ack_o, exp_ack);
                gate_now = (mode == 0) ||
                           (mode == 2 && (!en_i || (HOLD_ON && hold_i)));
                if (!sd_clk_o && gate_now) low_gated = 1;
                prev_gate = gate_now;
                prev_sd   = sd_clk_o;
                if (init_start_i && !sd_clk_o && mode != 1) start_due = 1;
                if (div_load_i) begin
                    m_pend     = div_i;
                    m_pend_vld = 1;
                end
            end
        end
    endtask

    // init from IDLE: 80 rises at 94-cycle levels, done 14949 edges later
    task automatic do_init();
        int n, r;
        @(posedge clk); #1 init_start_i = 1'b1;
        @(posedge clk); #1 init_start_i = 1'b0;
        n = 0;
        r = 0;
        do begin
            @(negedge clk);
            n++;
            if (rise_o) r++;
        end while (!init_done_o && n < LIMIT);
        chk("init_latency", n, 14949);
        chk("init_rises", r, 80);
    endtask

    initial begin
        int n, a, first;
        fork
            monitor();
        join_none

        rstn         = 1'b1;
        div_i        = '0;
        div_load_i   = 1'b0;
        en_i         = 1'b0;
        hold_i       = 1'b0;
        init_start_i = 1'b0;
        #3 rstn = 1'b0;
        #1;
        chk("rst_sd_clk", sd_clk_o, 1'b0);
        chk("rst_rise", rise_o, 1'b0);
        chk("rst_fall", fall_o, 1'b0);
        chk("rst_ack", div_ack_o, 1'b0);
        chk("rst_done", init_done_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;

        // init burst with en_i low: en_i must not matter in INIT
        do_init();

        // divisor 1 loaded during a high phase
        @(posedge clk); #1 en_i = 1'b1;
        wait_ev(0, n);
        @(posedge clk); #1 div_i = 8'd1; div_load_i = 1'b1;
        @(posedge clk); #1 div_load_i = 1'b0;
        wait_ev(2, n);
        chk("ack_latency", n, 93);
        wait_ev(0, n);
        chk("div1_low", n, 2);
        wait_ev(1, n);
        chk("div1_high", n, 2);

        // en_i dropped during high: level completes, then parks low
        wait_ev(0, n);
        @(posedge clk); #1 en_i = 1'b0;
        a = 0;
        first = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rise_o) a++;
            if (fall_o) first++;
        end
        chk("gated_rises", a, 0);
        chk("gated_falls", first, 1);
        chk("parked_low", sd_clk_o, 1'b0);
        @(posedge clk); #1 en_i = 1'b1;
        @(negedge clk);
        chk("ungate_early", rise_o, 1'b0);
        @(negedge clk);
        chk("ungate_rise", rise_o, 1'b1);

        // two loads in one high phase: last wins, single ack
        wait_ev(1, n);
        @(posedge clk); #1 div_i = 8'd5; div_load_i = 1'b1;
        @(posedge clk); #1 div_i = 8'd2;
        @(posedge clk); #1 div_load_i = 1'b0;
        a = 0;
        first = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (div_ack_o) begin
                a++;
                if (first == 0) first = i;
            end
        end
        chk("ack_count", a, 1);
        chk("ack_index", first, 2);
        wait_ev(1, n);
        wait_ev(0, n);
        chk("div2_low", n, 3);
        wait_ev(1, n);
        chk("div2_high", n, 3);

        // hold_i for 20 clocks starting mid-high
        wait_ev(0, n);
        @(posedge clk); #1 hold_i = 1'b1;
        a = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rise_o) a++;
        end
        @(posedge clk); #1 hold_i = 1'b0;
        chk("hold_rises", a, HOLD_ON ? 0 : 3);

        // re-init from RUN, reset at rise 40
        wait_ev(1, n);
        @(posedge clk); #1 init_start_i = 1'b1;
        @(posedge clk); #1 init_start_i = 1'b0;
        chk("reinit_busy", busy_o, 1'b1);
        repeat (40) wait_ev(0, n);
        chk("pre_rst_high", sd_clk_o, 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_sd_clk", sd_clk_o, 1'b0);
        chk("mid_rst_busy", busy_o, 1'b0);
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        a = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rise_o) a++;
        end
        chk("idle_rises", a, 0);
        do_init();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
